// File: rtl/dsp48a1_slice.sv
// DSP48A1-style slice: 18-bit pre-adder, 18x18 unsigned multiplier, 48-bit post-adder/accumulator.
// Optional cascade paths (BCIN, PCIN) are enabled by defining DSP_CASCADE_EN.
module dsp48a1_slice #(
  parameter int    A0REG       = 0,
  parameter int    A1REG       = 1,
  parameter int    B0REG       = 0,
  parameter int    B1REG       = 1,
  parameter int    CREG        = 1,
  parameter int    DREG        = 1,
  parameter int    MREG        = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT"
) (
  input  logic        clk,
  input  logic        RSTA,
  input  logic        RSTB,
  input  logic        RSTC,
  input  logic        RSTD,
  input  logic        RSTM,
  input  logic        RSTP,
  input  logic        RSTCARRYIN,
  input  logic        RSTOPMODE,
  input  logic        CEA,
  input  logic        CEB,
  input  logic        CEC,
  input  logic        CED,
  input  logic        CEM,
  input  logic        CEP,
  input  logic        CECARRYIN,
  input  logic        CEOPMODE,
  input  logic [17:0] A,
  input  logic [17:0] B,
  input  logic [17:0] D,
  input  logic [17:0] BCIN,
  input  logic [47:0] C,
  input  logic [47:0] PCIN,
  input  logic        CARRYIN,
  input  logic [7:0]  OPMODE,
  output logic [17:0] BCOUT,
  output logic [35:0] M,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic        CARRYOUT,
  output logic        CARRYOUTF
);

  logic [17:0] a0_r, a1_r, b0_r, b1_r, d_r;
  logic [47:0] c_r, p_r;
  logic [35:0] m_r;
  logic [7:0]  opm_r;
  logic        cyi_r, co_r;

  logic [17:0] a0, a1, b_sel, b0, b1, b1_in, d, preadd;
  logic [47:0] c, x, z, pcin_eff;
  logic [35:0] mult;
  logic [7:0]  opm;
  logic        cin_src, cyi;
  logic [48:0] sum;

`ifdef DSP_CASCADE_EN
  assign b_sel = (B_INPUT == "DIRECT")  ? B :
                 (B_INPUT == "CASCADE") ? BCIN : 18'd0;
  assign pcin_eff = PCIN;
`else
  logic unused_cascade;
  assign unused_cascade = ^{BCIN, PCIN};
  assign b_sel    = B;
  assign pcin_eff = 48'd0;
`endif

  // Stage 0 registers
  always_ff @(posedge clk or posedge RSTA)
    if (RSTA)     a0_r <= '0;
    else if (CEA) a0_r <= A;

  always_ff @(posedge clk or posedge RSTB)
    if (RSTB)     b0_r <= '0;
    else if (CEB) b0_r <= b_sel;

  always_ff @(posedge clk or posedge RSTD)
    if (RSTD)     d_r <= '0;
    else if (CED) d_r <= D;

  always_ff @(posedge clk or posedge RSTC)
    if (RSTC)     c_r <= '0;
    else if (CEC) c_r <= C;

  always_ff @(posedge clk or posedge RSTOPMODE)
    if (RSTOPMODE)     opm_r <= '0;
    else if (CEOPMODE) opm_r <= OPMODE;

  assign a0  = (A0REG != 0)     ? a0_r  : A;
  assign b0  = (B0REG != 0)     ? b0_r  : b_sel;
  assign d   = (DREG != 0)      ? d_r   : D;
  assign c   = (CREG != 0)      ? c_r   : C;
  assign opm = (OPMODEREG != 0) ? opm_r : OPMODE;

  assign preadd = opm[6] ? (d - b0) : (d + b0);
  assign b1_in  = opm[4] ? preadd : b0;

  // Stage 1 registers (multiplier inputs)
  always_ff @(posedge clk or posedge RSTA)
    if (RSTA)     a1_r <= '0;
    else if (CEA) a1_r <= a0;

  always_ff @(posedge clk or posedge RSTB)
    if (RSTB)     b1_r <= '0;
    else if (CEB) b1_r <= b1_in;

  assign a1    = (A1REG != 0) ? a1_r : a0;
  assign b1    = (B1REG != 0) ? b1_r : b1_in;
  assign BCOUT = b1;

  assign mult = {18'd0, b1} * {18'd0, a1};

  always_ff @(posedge clk or posedge RSTM)
    if (RSTM)     m_r <= '0;
    else if (CEM) m_r <= mult;

  assign M = (MREG != 0) ? m_r : mult;

  assign cin_src = (CARRYINSEL == "OPMODE5") ? opm[5] :
                   (CARRYINSEL == "CARRYIN") ? CARRYIN : 1'b0;

  always_ff @(posedge clk or posedge RSTCARRYIN)
    if (RSTCARRYIN)     cyi_r <= 1'b0;
    else if (CECARRYIN) cyi_r <= cin_src;

  assign cyi = (CARRYINREG != 0) ? cyi_r : cin_src;

  // P feedback always comes from the P register so X=P / Z=P never forms a combinational loop
  always_comb begin
    x = 48'd0;
    case (opm[1:0])
      2'd0: x = 48'd0;
      2'd1: x = {12'd0, M};
      2'd2: x = p_r;
      2'd3: x = {d[11:0], a1, b1};
      default: x = 48'd0;
    endcase
  end

  always_comb begin
    z = 48'd0;
    case (opm[3:2])
      2'd0: z = 48'd0;
      2'd1: z = pcin_eff;
      2'd2: z = p_r;
      2'd3: z = c;
      default: z = 48'd0;
    endcase
  end

  assign sum = opm[7] ? ({1'b0, z} - ({1'b0, x} + {48'd0, cyi}))
                      : ({1'b0, z} + {1'b0, x} + {48'd0, cyi});

  always_ff @(posedge clk or posedge RSTP)
    if (RSTP)     p_r <= '0;
    else if (CEP) p_r <= sum[47:0];

  always_ff @(posedge clk or posedge RSTCARRYIN)
    if (RSTCARRYIN)     co_r <= 1'b0;
    else if (CECARRYIN) co_r <= sum[48];

  assign P         = (PREG != 0) ? p_r : sum[47:0];
  assign PCOUT     = P;
  assign CARRYOUT  = (CARRYOUTREG != 0) ? co_r : sum[48];
  assign CARRYOUTF = CARRYOUT;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// Scoreboard bench for dsp48a1_slice: stimulus pushes expected values, a monitor pops and compares.
module tb_dsp48a1_slice;
  logic        clk = 1'b0;
  logic        RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE;
  logic        CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE;
  logic [17:0] A, B, D, BCIN;
  logic [47:0] C, PCIN;
  logic        CARRYIN;
  logic [7:0]  OPMODE;
  logic [17:0] BCOUT;
  logic [35:0] M;
  logic [47:0] P, PCOUT;
  logic        CARRYOUT, CARRYOUTF;

  dsp48a1_slice dut (
    .clk(clk), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD), .RSTM(RSTM),
    .RSTP(RSTP), .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
    .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM), .CEP(CEP),
    .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
    .A(A), .B(B), .D(D), .BCIN(BCIN), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN),
    .OPMODE(OPMODE), .BCOUT(BCOUT), .M(M), .P(P), .PCOUT(PCOUT),
    .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
  );

  always #5 clk = ~clk;

`ifdef DSP_CASCADE_EN
  localparam logic [47:0] EXP_P2  = 48'd42;
  localparam logic [47:0] EXP_P3A = 48'd84;
  localparam logic [47:0] EXP_P3B = 48'd168;
  localparam logic [47:0] EXP_P3C = 48'd336;
  localparam logic [47:0] EXP_P4  = 48'hFFFF_FFFF_FFE2;
`else
  localparam logic [47:0] EXP_P2  = 48'd36;
  localparam logic [47:0] EXP_P3A = 48'd72;
  localparam logic [47:0] EXP_P3B = 48'd144;
  localparam logic [47:0] EXP_P3C = 48'd288;
  localparam logic [47:0] EXP_P4  = 48'hFFFF_FFFF_FFDC;
`endif

  localparam int SEL_P = 0, SEL_M = 1, SEL_BC = 2, SEL_CO = 3, SEL_PC = 4, SEL_COF = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [47:0] exp;
  } chk_t;

  chk_t sb[$];
  event push_ev;
  int   total = 0;
  int   bad   = 0;

  task automatic expect_out(input string name, input int sel, input logic [47:0] exp);
    chk_t it;
    it.name = name;
    it.sel  = sel;
    it.exp  = exp;
    sb.push_back(it);
  endtask

  task automatic flush_checks();
    ->push_ev;
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_all_rst(input logic v);
    {RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE} = {8{v}};
  endtask

  task automatic set_all_ce(input logic v);
    {CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE} = {8{v}};
  endtask

  // Monitor: drains the scoreboard whenever the stimulus signals that outputs are ready
  initial begin
    chk_t        it;
    logic [47:0] act;
    forever begin
      @(push_ev);
      while (sb.size() > 0) begin
        it = sb.pop_front();
        case (it.sel)
          SEL_P:   act = P;
          SEL_M:   act = {12'd0, M};
          SEL_BC:  act = {30'd0, BCOUT};
          SEL_CO:  act = {47'd0, CARRYOUT};
          SEL_PC:  act = PCOUT;
          default: act = {47'd0, CARRYOUTF};
        endcase
        total++;
        if (act !== it.exp) begin
          bad++;
          $display("FAIL %s: got %0h want %0h", it.name, act, it.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    set_all_rst(1'b1);
    set_all_ce(1'b1);
    A = 0; B = 0; D = 0; BCIN = 0; C = 0; PCIN = 0; CARRYIN = 0; OPMODE = 0;

    // 1: reset held across clock edges
    cycles(8);
    expect_out("rst_p", SEL_P, 48'd0);
    expect_out("rst_m", SEL_M, 48'd0);
    expect_out("rst_bcout", SEL_BC, 48'd0);
    expect_out("rst_co", SEL_CO, 48'd0);
    flush_checks();

    // 2: multiply-add with pre-adder
    set_all_rst(1'b0);
    D = 18'd5; B = 18'd7; A = 18'd3; PCIN = 48'd6; OPMODE = 8'h15;
    cycles(8);
    expect_out("mac_bcout", SEL_BC, 48'd12);
    expect_out("mac_m", SEL_M, 48'd36);
    expect_out("mac_p", SEL_P, EXP_P2);
    expect_out("mac_pcout", SEL_PC, EXP_P2);
    expect_out("mac_co", SEL_CO, 48'd0);
    flush_checks();

    // 3: P accumulates onto itself; opmode register edge, then P edge
    OPMODE = 8'h1A;
    cycles(2);
    expect_out("acc_p1", SEL_P, EXP_P3A);
    flush_checks();
    cycles(1);
    expect_out("acc_p2", SEL_P, EXP_P3B);
    flush_checks();
    cycles(1);
    expect_out("acc_p3", SEL_P, EXP_P3C);
    flush_checks();

    // 4: subtract mode, borrow out
    D = 18'd5; B = 18'd7; A = 18'd3; C = 48'd2; PCIN = 48'd6; OPMODE = 8'h95;
    cycles(8);
    expect_out("sub_p", SEL_P, EXP_P4);
    expect_out("sub_m", SEL_M, 48'd36);
    expect_out("sub_co", SEL_CO, 48'd1);
    expect_out("sub_cof", SEL_COF, 48'd1);
    flush_checks();

    // 5: all clock enables low, inputs wander
    set_all_ce(1'b0);
    D = 18'd1; B = 18'd2; A = 18'd9; C = 48'd9; PCIN = 48'd100; OPMODE = 8'h00;
    cycles(8);
    expect_out("hold_p", SEL_P, EXP_P4);
    expect_out("hold_m", SEL_M, 48'd36);
    expect_out("hold_bcout", SEL_BC, 48'd12);
    expect_out("hold_co", SEL_CO, 48'd1);
    flush_checks();

    // 6: pre-subtract, C + M + carry-in, then asynchronous P reset
    set_all_ce(1'b1);
    D = 18'd50; B = 18'd17; A = 18'd37; C = 48'd2; OPMODE = 8'h7D;
    cycles(8);
    expect_out("c_bcout", SEL_BC, 48'd33);
    expect_out("c_m", SEL_M, 48'd1221);
    expect_out("c_p", SEL_P, 48'd1224);
    expect_out("c_co", SEL_CO, 48'd0);
    flush_checks();
    #2;
    RSTP = 1'b1;
    #1;
    expect_out("rstp_async_p", SEL_P, 48'd0);
    expect_out("rstp_keeps_m", SEL_M, 48'd1221);
    flush_checks();
    cycles(1);
    expect_out("rstp_held_p", SEL_P, 48'd0);
    flush_checks();
    RSTP = 1'b0;
    cycles(1);
    expect_out("rstp_release_p", SEL_P, 48'd1224);
    flush_checks();

    if (sb.size() != 0) begin
      bad++;
      total++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
